upc_sequencer: RTL and testbench
================================

# upc_sequencer

Micro-program counter and return-stack sequencer for the microcoded control unit. It holds the 8-bit micro-PC that feeds both the control-store ROM and the next-address selector. Each advancing cycle it registers the selector's result as the new micro-PC. It also keeps a small call/return stack, whose top entry and select flag drive the selector's return-override input pair (`control2` / `control2_out`).

## Interface
- `ADDR_W`, default 8: micro-address width.
- `STACK_DEPTH`, default 4: return-stack entries; must be a power of two, at least 2.
- `RESET_ADDR`, default 8'h00: micro-PC value on reset.

Ports:
- `clk`  in  1  sole clock; all state updates on its rising edge.
- `rst_n`  in  1  reset; asynchronous, active-low.
- `next_addr`  in  ADDR_W  next micro-address from the next-address selector.
- `en`  in  1  advance enable; 0 freezes the sequencer in RUN.
- `call`  in  1  push return address (pc+1) this cycle.
- `ret`  in  1  return request this cycle.
- `halt_req`  in  1  enter HALT.
- `resume`  in  1  leave HALT.
- `pc`  out  ADDR_W  current micro-PC, registered.
- `ret_sel`  out  1  return-override select to the selector; combinational.
- `ret_addr`  out  ADDR_W  top-of-stack to the selector; combinational.
- `stack_empty`  out  1  depth == 0.
- `stack_full`  out  1  depth == STACK_DEPTH.
- `ovf_err`  out  1  sticky overflow flag.
- `unf_err`  out  1  sticky underflow flag.
- `state`  out  2  IDLE=0, RUN=1, HALT=2.

## Operation
- **Reset** (while `rst_n`=0): `pc`=RESET_ADDR, depth=0, `ovf_err`=`unf_err`=0, `state`=IDLE, `ret_sel`=0, `ret_addr`=0.
- **IDLE**: a single ROM-fetch bubble. It goes to RUN on the next edge unconditionally. `pc` holds and all inputs are ignored.
- **RUN** priority, highest first:
  1. `halt_req`=1: go to HALT. `pc` holds and the stack is untouched.
  2. `en`=0: hold everything.
  3. Otherwise advance: `pc` <= `next_addr`, and stack operations apply.
- **HALT**: `pc` and stack hold. It returns to RUN on the edge where `resume`=1. `halt_req` is ignored while in HALT.
- **ret_sel**: `ret_sel` = `ret` & !`stack_empty` & (state==RUN) & `en` & !`halt_req`.
- **ret_addr**: equals the top entry when the stack is non-empty, otherwise 0.
- **Call**: pushes (`pc`+1) mod 2^ADDR_W, so 8'hFF pushes 8'h00. If the stack is full, no push happens and `ovf_err` sets; `pc` still advances.
- **Return**: pops one entry. If the stack is empty, no pop happens, `unf_err` sets, and `pc` <= `next_addr` (the override is not asserted).
- **Call and ret in the same advancing cycle**: the return uses the current top, then that entry is overwritten with `pc`+1, so depth is unchanged. If the stack is empty, `unf_err` sets and the push proceeds (depth becomes 1).
- **Error flags**: cleared only by reset.
- **Stack storage**: register array indexed by a stack pointer; no wrap. Push and pop are guarded by full/empty as above.

## Timing
- Latency: `next_addr` is sampled at edge N and appears on `pc` after edge N, one cycle.
- The selector's result feeds back to `next_addr` combinationally in the same cycle; the selector includes the `ret_sel`/`ret_addr` override.
- `stack_empty`, `stack_full`, the error flags and `state` update on the same edge as the stack operation that changes them.
- Reset asserted mid-operation clears everything immediately (asynchronously). After `rst_n` deasserts, the first edge enters IDLE→RUN. The first advance occurs on the second edge.
- No handshake beyond `en`: the upstream side must hold `call`/`ret` for exactly the cycle in which it intends the operation.

## Structure
- A shared package `upc_pkg` holds the state enum (IDLE/RUN/HALT) and the defaults for ADDR_W and RESET_ADDR. The next-address selector and control-store modules import the same package.
- One sub-module is natural: `upc_ret_stack`, which provides push/pop/replace, top, empty/full and ovf/unf pulses.
- The top level holds the FSM, the `pc` register and the error stickies.

## Test plan
- **Reset release, `en`=1, `next_addr`=8'h10**: `pc`=00 for two edges (IDLE then first RUN edge), then 10; `state` goes 0→1.
- **Call at `pc`=8'h20 with `next_addr`=8'h40, then `ret` at `pc`=8'h45**: `ret_sel`=1 and `ret_addr`=8'h21 during the return cycle; the stack ends empty.
- **Five calls with no returns (depth 4)**: `stack_full`=1 after the 4th; `ovf_err`=1 after the 5th; `pc` keeps following `next_addr`.
- **`ret` with an empty stack**: `ret_sel`=0, `unf_err`=1, `pc` <= `next_addr`.
- **Simultaneous call+ret at `pc`=8'hFF with top=8'h33**: `ret_addr`=33 and the new top=8'h00 with depth unchanged. Then `halt_req` holds `pc` for 3 cycles, and `resume` restores RUN.
- **`rst_n` pulsed low mid-stack (depth 3)**: immediate `pc`=RESET_ADDR, depth 0, flags 0, `state`=IDLE.

Source files
------------

// File: rtl/upc_pkg.sv
// Shared definitions for the microcoded control unit: sequencer state
// encoding and default micro-address parameters.
package upc_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } upc_state_t;

    localparam int unsigned     UPC_ADDR_W     = 8;
    localparam logic [7:0]      UPC_RESET_ADDR = 8'h00;

endpackage

// File: rtl/upc_ret_stack.sv
// Return-address stack for the micro-sequencer: push, pop, replace-top,
// with full/empty guards and single-cycle overflow/underflow pulses.
module upc_ret_stack #(
    parameter int unsigned ADDR_W      = 8,
    parameter int unsigned STACK_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push,
    input  logic              pop,
    input  logic [ADDR_W-1:0] push_data,
    output logic [ADDR_W-1:0] top,
    output logic              empty,
    output logic              full,
    output logic              ovf,
    output logic              unf
);

    localparam int unsigned PTR_W = $clog2(STACK_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [ADDR_W-1:0] mem [STACK_DEPTH];
    logic [CNT_W-1:0]  cnt;
    logic [PTR_W-1:0]  top_idx;
    logic [PTR_W-1:0]  wr_idx;

    assign empty   = (cnt == '0);
    assign full    = (cnt == CNT_W'(STACK_DEPTH));
    assign top_idx = PTR_W'(cnt - CNT_W'(1));
    assign wr_idx  = cnt[PTR_W-1:0];
    assign top     = empty ? '0 : mem[top_idx];

    // A simultaneous push+pop on a non-empty stack replaces the top, so it
    // can never overflow; on an empty stack the pop underflows and the push lands.
    assign ovf = push && !pop && full;
    assign unf = pop && empty;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
            for (int unsigned i = 0; i < STACK_DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (push && pop) begin
            if (empty) begin
                mem[wr_idx] <= push_data;
                cnt         <= cnt + CNT_W'(1);
            end else begin
                mem[top_idx] <= push_data;
            end
        end else if (push) begin
            if (!full) begin
                mem[wr_idx] <= push_data;
                cnt         <= cnt + CNT_W'(1);
            end
        end else if (pop) begin
            if (!empty) begin
                cnt <= cnt - CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/upc_sequencer.sv
// Micro-program counter with IDLE/RUN/HALT control and a call/return stack
// that drives the next-address selector's return override.
module upc_sequencer
    import upc_pkg::*;
#(
    parameter int unsigned       ADDR_W      = UPC_ADDR_W,
    parameter int unsigned       STACK_DEPTH = 4,
    parameter logic [ADDR_W-1:0] RESET_ADDR  = ADDR_W'(UPC_RESET_ADDR)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] next_addr,
    input  logic              en,
    input  logic              call,
    input  logic              ret,
    input  logic              halt_req,
    input  logic              resume,
    output logic [ADDR_W-1:0] pc,
    output logic              ret_sel,
    output logic [ADDR_W-1:0] ret_addr,
    output logic              stack_empty,
    output logic              stack_full,
    output logic              ovf_err,
    output logic              unf_err,
    output logic [1:0]        state
);

    upc_state_t st;
    logic       advance;
    logic       stk_ovf;
    logic       stk_unf;

    assign advance = (st == RUN) && en && !halt_req;
    assign ret_sel = ret && !stack_empty && advance;
    assign state   = st;

    upc_ret_stack #(
        .ADDR_W      (ADDR_W),
        .STACK_DEPTH (STACK_DEPTH)
    ) u_ret_stack (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (call && advance),
        .pop       (ret && advance),
        .push_data (pc + ADDR_W'(1)),
        .top       (ret_addr),
        .empty     (stack_empty),
        .full      (stack_full),
        .ovf       (stk_ovf),
        .unf       (stk_unf)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st      <= IDLE;
            pc      <= RESET_ADDR;
            ovf_err <= 1'b0;
            unf_err <= 1'b0;
        end else begin
            unique case (st)
                IDLE: st <= RUN;
                RUN: begin
                    if (halt_req) begin
                        st <= HALT;
                    end else if (en) begin
                        pc <= next_addr;
                        if (stk_ovf) ovf_err <= 1'b1;
                        if (stk_unf) unf_err <= 1'b1;
                    end
                end
                HALT: if (resume) st <= RUN;
                default: st <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_upc_sequencer.sv
// Directed self-checking bench for upc_sequencer with hand-computed expectations.
module tb_upc_sequencer;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] next_addr = 8'h10;
    logic       en = 1'b1;
    logic       call = 1'b0;
    logic       ret = 1'b0;
    logic       halt_req = 1'b0;
    logic       resume = 1'b0;
    logic [7:0] pc;
    logic       ret_sel;
    logic [7:0] ret_addr;
    logic       stack_empty;
    logic       stack_full;
    logic       ovf_err;
    logic       unf_err;
    logic [1:0] state;

    int checks = 0;
    int errors = 0;

    upc_sequencer #(
        .ADDR_W      (8),
        .STACK_DEPTH (4),
        .RESET_ADDR  (8'h00)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .next_addr   (next_addr),
        .en          (en),
        .call        (call),
        .ret         (ret),
        .halt_req    (halt_req),
        .resume      (resume),
        .pc          (pc),
        .ret_sel     (ret_sel),
        .ret_addr    (ret_addr),
        .stack_empty (stack_empty),
        .stack_full  (stack_full),
        .ovf_err     (ovf_err),
        .unf_err     (unf_err),
        .state       (state)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_cleared(input string tag);
        chk({tag, "_pc"},    32'(pc), 32'h00);
        chk({tag, "_state"}, 32'(state), 32'd0);
        chk({tag, "_empty"}, 32'(stack_empty), 32'd1);
        chk({tag, "_full"},  32'(stack_full), 32'd0);
        chk({tag, "_ovf"},   32'(ovf_err), 32'd0);
        chk({tag, "_unf"},   32'(unf_err), 32'd0);
        chk({tag, "_rsel"},  32'(ret_sel), 32'd0);
        chk({tag, "_raddr"}, 32'(ret_addr), 32'h00);
    endtask

    initial begin
        // reset state
        #12;
        chk_cleared("rst");
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        chk("idle_state", 32'(state), 32'd1);
        chk("idle_pc",    32'(pc), 32'h00);
        tick();
        chk("first_adv_pc", 32'(pc), 32'h10);

        // call at 0x20, return from 0x45
        next_addr = 8'h20; tick();
        chk("pc20", 32'(pc), 32'h20);
        call = 1'b1; next_addr = 8'h40; tick();
        call = 1'b0;
        chk("call_pc",    32'(pc), 32'h40);
        chk("call_top",   32'(ret_addr), 32'h21);
        chk("call_empty", 32'(stack_empty), 32'd0);
        next_addr = 8'h45; tick();
        ret = 1'b1; next_addr = 8'h21; #1;
        chk("ret_sel",  32'(ret_sel), 32'd1);
        chk("ret_addr", 32'(ret_addr), 32'h21);
        tick();
        ret = 1'b0;
        chk("ret_pc",    32'(pc), 32'h21);
        chk("ret_empty", 32'(stack_empty), 32'd1);
        chk("ret_raddr0", 32'(ret_addr), 32'h00);

        // five calls into a depth-4 stack
        call = 1'b1;
        for (int i = 0; i < 5; i++) begin
            next_addr = 8'h50 + 8'(i);
            tick();
            chk("calls_pc", 32'(pc), 32'h50 + 32'(i));
            chk("calls_full", 32'(stack_full), (i >= 3) ? 32'd1 : 32'd0);
            chk("calls_ovf",  32'(ovf_err), (i >= 4) ? 32'd1 : 32'd0);
        end
        call = 1'b0;
        chk("calls_top", 32'(ret_addr), 32'h53);

        // en=0 holds everything
        en = 1'b0; next_addr = 8'h99; call = 1'b1; tick();
        call = 1'b0; en = 1'b1;
        chk("hold_pc",  32'(pc), 32'h54);
        chk("hold_ovf_unf", 32'(unf_err), 32'd0);

        // drain: expected tops 53, 52, 51, 22
        ret = 1'b1;
        next_addr = 8'h53; #1; chk("pop1_addr", 32'(ret_addr), 32'h53); tick();
        next_addr = 8'h52; #1; chk("pop2_addr", 32'(ret_addr), 32'h52); tick();
        next_addr = 8'h51; #1; chk("pop3_addr", 32'(ret_addr), 32'h51); tick();
        next_addr = 8'h22; #1; chk("pop4_addr", 32'(ret_addr), 32'h22);
        chk("pop4_sel", 32'(ret_sel), 32'd1);
        tick();
        chk("drained_empty", 32'(stack_empty), 32'd1);
        chk("drained_full",  32'(stack_full), 32'd0);

        // return from empty stack
        next_addr = 8'h66; #1;
        chk("unf_sel", 32'(ret_sel), 32'd0);
        tick();
        ret = 1'b0;
        chk("unf_pc",   32'(pc), 32'h66);
        chk("unf_flag", 32'(unf_err), 32'd1);
        chk("ovf_sticky", 32'(ovf_err), 32'd1);

        // call+ret at pc=FF with top=33
        next_addr = 8'h32; tick();
        call = 1'b1; next_addr = 8'hFF; tick();
        chk("pcff", 32'(pc), 32'hFF);
        chk("top33", 32'(ret_addr), 32'h33);
        ret = 1'b1; next_addr = 8'h33; #1;
        chk("cr_sel",  32'(ret_sel), 32'd1);
        chk("cr_addr", 32'(ret_addr), 32'h33);
        tick();
        call = 1'b0;
        chk("cr_pc",    32'(pc), 32'h33);
        chk("cr_top",   32'(ret_addr), 32'h00);
        chk("cr_empty", 32'(stack_empty), 32'd0);

        // halt for three cycles with ret held; no override and no pop
        halt_req = 1'b1; next_addr = 8'h77; #1;
        chk("halt_req_sel", 32'(ret_sel), 32'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("halt_state", 32'(state), 32'd2);
            chk("halt_pc",    32'(pc), 32'h33);
            chk("halt_sel",   32'(ret_sel), 32'd0);
        end
        chk("halt_empty", 32'(stack_empty), 32'd0);
        halt_req = 1'b0; ret = 1'b0; resume = 1'b1; tick();
        resume = 1'b0;
        chk("resume_state", 32'(state), 32'd1);
        chk("resume_pc",    32'(pc), 32'h33);

        // single remaining entry is the 00 written by call+ret
        ret = 1'b1; next_addr = 8'h00; #1;
        chk("post_sel",  32'(ret_sel), 32'd1);
        chk("post_addr", 32'(ret_addr), 32'h00);
        tick();
        chk("post_empty", 32'(stack_empty), 32'd1);

        // call+ret on empty stack: underflow, push still lands
        call = 1'b1; next_addr = 8'h05; #1;
        chk("cre_sel", 32'(ret_sel), 32'd0);
        tick();
        call = 1'b0; ret = 1'b0;
        chk("cre_pc",    32'(pc), 32'h05);
        chk("cre_empty", 32'(stack_empty), 32'd0);
        chk("cre_top",   32'(ret_addr), 32'h01);

        // reach depth 3 then reset asynchronously
        call = 1'b1; next_addr = 8'h0A; tick();
        next_addr = 8'h0B; tick();
        call = 1'b0;
        chk("d3_top", 32'(ret_addr), 32'h0B);
        #2;
        rst_n = 1'b0;
        #1;
        chk_cleared("async_rst");
        @(negedge clk);
        rst_n = 1'b1;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
